sin_taylor_engine: RTL and testbench

//  Iterative fixed-point sine unit: sinx = sum_{k=0}^{n-1} (-1)^k x^(2k+1)/(2k+1)!.
//  It is the parametrised successor of the fixed 16-bit sine datapath.

---
 rtl/sin_taylor_engine.sv | 167 ++++++++++++++++
 tb/tb_sin_taylor_engine.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sin_taylor_engine.sv
// rtl/sin_taylor_engine.sv - iterative fixed-point Taylor-series sine with one time-shared multiplier
// Each extra term costs a MULX (term*x^2) and a MULC (scale by -1/((2k)(2k+1))) cycle.
module sin_taylor_engine #(
    parameter int DW        = 16,
    parameter int FRAC      = 14,
    parameter int MAX_TERMS = 8,
    parameter int RFRAC     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] x,
    input  logic [7:0]           y,
    input  logic                 start,
    output logic                 ready,
    output logic                 done,
    output logic signed [DW-1:0] sinx
);

    // Intermediate terms reach x^3 ~ 8.0 for |x| near 2, so they get headroom beyond DW.
    localparam int TW = DW + 8;
    localparam int AW = DW + 2;
    localparam int KW = $clog2(MAX_TERMS) + 1;
    localparam int IW = $clog2(MAX_TERMS);
    localparam int PW = 2 * TW;

    localparam logic signed [AW-1:0] SAT_HI = AW'((1 << (DW - 1)) - 1);
    localparam logic signed [AW-1:0] SAT_LO = -AW'(1 << (DW - 1));

    typedef enum logic [2:0] {
        S_IDLE,
        S_SQR,
        S_MULX,
        S_MULC,
        S_DONE
    } state_t;

    state_t r_state, w_next;

    logic signed [DW-1:0] r_xr;
    logic signed [TW-1:0] r_x2;
    logic signed [TW-1:0] r_term;
    logic signed [AW-1:0] r_acc;
    logic [KW-1:0]        r_k;
    logic [KW-1:0]        r_nr;
    logic signed [DW-1:0] r_sinx;

    logic [KW-1:0]        w_n;
    logic [KW-1:0]        w_k_inc;
    logic [RFRAC-1:0]     w_rom [MAX_TERMS];
    logic [RFRAC-1:0]     w_recip;
    logic signed [TW-1:0] w_opa, w_opb;
    logic signed [PW-1:0] w_prod;
    logic signed [TW-1:0] w_mres;
    logic signed [TW-1:0] w_t;
    logic signed [AW-1:0] w_acc_nx;
    logic                 w_unused_bits;

    for (genvar g = 0; g < MAX_TERMS; g++) begin : g_rom
        localparam longint D = (g == 0) ? 1 : (2 * g) * (2 * g + 1);
        assign w_rom[g] = (g == 0) ? '0 : RFRAC'(((64'd1 << RFRAC) + D / 2) / D);
    end

    always_comb begin
        w_n = KW'(1);
        if (y == 8'd0)
            w_n = KW'(1);
        else if (y > 8'(MAX_TERMS))
            w_n = KW'(MAX_TERMS);
        else
            w_n = y[KW-1:0];
    end

    assign w_k_inc = r_k + KW'(1);
    assign w_recip = w_rom[r_k[IW-1:0]];

    always_comb begin
        w_opa = r_term;
        w_opb = r_x2;
        case (r_state)
            S_SQR: begin
                w_opa = {{(TW - DW){r_xr[DW-1]}}, r_xr};
                w_opb = {{(TW - DW){r_xr[DW-1]}}, r_xr};
            end
            S_MULC:  w_opb = {{(TW - RFRAC){1'b0}}, w_recip};
            default: ;
        endcase
    end

    assign w_prod = w_opa * w_opb;
    // Selecting a bit window of the product is the arithmetic shift, truncating toward -inf.
    assign w_mres = (r_state == S_MULC) ? w_prod[RFRAC +: TW] : w_prod[FRAC +: TW];
    assign w_unused_bits = ^{w_prod[PW-1:FRAC+TW], w_prod[FRAC-1:0]};

    assign w_t      = -w_mres;
    assign w_acc_nx = r_acc + w_t[AW-1:0];

    function automatic logic signed [DW-1:0] f_sat(input logic signed [AW-1:0] a);
        if (a > SAT_HI)
            return SAT_HI[DW-1:0];
        else if (a < SAT_LO)
            return SAT_LO[DW-1:0];
        else
            return a[DW-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_SQR;
            S_SQR:   w_next = (r_nr == KW'(1)) ? S_DONE : S_MULX;
            S_MULX:  w_next = S_MULC;
            S_MULC:  w_next = (w_k_inc == r_nr) ? S_DONE : S_MULX;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_xr   <= '0;
            r_x2   <= '0;
            r_term <= '0;
            r_acc  <= '0;
            r_k    <= '0;
            r_nr   <= '0;
            r_sinx <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_xr   <= x;
                        r_nr   <= w_n;
                        r_term <= {{(TW - DW){x[DW-1]}}, x};
                        r_acc  <= {{(AW - DW){x[DW-1]}}, x};
                        r_k    <= KW'(1);
                    end
                end
                S_SQR: begin
                    r_x2 <= w_mres;
                    if (r_nr == KW'(1))
                        r_sinx <= f_sat(r_acc);
                end
                S_MULX: r_term <= w_mres;
                S_MULC: begin
                    r_term <= w_t;
                    r_acc  <= w_acc_nx;
                    r_k    <= w_k_inc;
                    if (w_k_inc == r_nr)
                        r_sinx <= f_sat(w_acc_nx);
                end
                default: ;
            endcase
        end
    end

    assign ready = (r_state == S_IDLE);
    assign done  = (r_state == S_DONE);
    assign sinx  = r_sinx;

endmodule

// File: tb/tb_sin_taylor_engine.sv
// tb/tb_sin_taylor_engine.sv - directed self-checking bench for sin_taylor_engine
module tb_sin_taylor_engine;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [15:0] x = '0;
    logic [7:0]         y = '0;
    logic               start = 1'b0;
    logic               ready;
    logic               done;
    logic signed [15:0] sinx;

    int n_checks = 0;
    int n_errors = 0;

    sin_taylor_engine dut (
        .clk   (clk),
        .rst   (rst),
        .x     (x),
        .y     (y),
        .start (start),
        .ready (ready),
        .done  (done),
        .sinx  (sinx)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp, input int tol = 0);
        n_checks++;
        if (got - exp > tol || exp - got > tol) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    task automatic wait_ready();
        int cnt;
        cnt = 0;
        @(negedge clk);
        while (!ready && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("wait_ready", int'(ready), 1);
    endtask

    // Latency is the number of edges from the accept edge to the edge that sees done high.
    task automatic run_op(input logic signed [15:0] ax, input logic [7:0] ay, input bit poke,
                          output int res, output int lat);
        bit d, r;
        res = 0;
        lat = -1;
        wait_ready();
        x = ax;
        y = ay;
        start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            if (i == 1) begin
                x = ~ax;
                y = ay + 8'd1;
            end
            if (poke && i == 3) begin
                start = 1'b1;
                x = 16'sd1000;
                y = 8'd1;
            end
            if (poke && i == 4) start = 1'b0;
            d = done;
            r = ready;
            if (d) begin
                res = int'(sinx);
                check("ready_done_excl", int'(r), 0);
            end
            @(posedge clk);
            if (d) begin
                lat = i + 1;
                break;
            end
        end
        if (lat < 0) check("done_timeout", 0, 1);
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        check({tag, "_ready"}, int'(ready), 1);
        check({tag, "_done"}, int'(done), 0);
    endtask

    int res, lat;
    int acc_e[2];
    int res6[2];
    int na, nres, e;
    bit r6, d6;

    initial begin
        // 1: reset state and a zero angle
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", int'(ready), 1);
        check("rst_done", int'(done), 0);
        check("rst_sinx", int'(sinx), 0);
        rst = 1'b0;
        run_op(16'sd0, 8'd4, 1'b0, res, lat);
        check("zero_sinx", res, 0);
        check("zero_lat", lat, 8);
        check_idle("zero_after");

        // 2: sin(+-0.5)
        run_op(16'sd8192, 8'd4, 1'b0, res, lat);
        check("half_sinx", res, 7855, 2);
        check("half_lat", lat, 8);
        run_op(-16'sd8192, 8'd4, 1'b0, res, lat);
        check("neg_half_sinx", res, -7855, 2);

        // 3: sin(pi/2), and clamping of an oversized term count
        run_op(16'sd25736, 8'd6, 1'b0, res, lat);
        check("pi2_sinx", res, 16384, 4);
        check("pi2_lat", lat, 12);
        run_op(16'sd25736, 8'd200, 1'b0, res, lat);
        check("clamp_sinx", res, 16384, 4);
        check("clamp_lat", lat, 16);

        // 4: single-term runs, then a start pulse while busy
        run_op(16'sd3000, 8'd0, 1'b0, res, lat);
        check("y0_sinx", res, 3000);
        check("y0_lat", lat, 2);
        run_op(16'sd3000, 8'd1, 1'b0, res, lat);
        check("y1_sinx", res, 3000);
        check("y1_lat", lat, 2);
        run_op(16'sd8192, 8'd8, 1'b1, res, lat);
        check("busy_sinx", res, 7855, 2);
        check("busy_lat", lat, 16);
        check_idle("busy_after");
        @(negedge clk);
        check("busy_no_queue_done", int'(done), 0);
        check("busy_no_queue_ready", int'(ready), 1);

        // 5: reset while in MULC
        wait_ready();
        x = 16'sd8192;
        y = 8'd4;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_ready", int'(ready), 1);
        check("midrst_done", int'(done), 0);
        check("midrst_sinx", int'(sinx), 0);
        rst = 1'b0;
        run_op(16'sd3000, 8'd1, 1'b0, res, lat);
        check("post_rst_sinx", res, 3000);
        check("post_rst_lat", lat, 2);

        // 6: start held high gives back-to-back runs
        wait_ready();
        x = 16'sd8192;
        y = 8'd3;
        start = 1'b1;
        na = 0;
        nres = 0;
        e = 0;
        for (int i = 0; i < 80 && nres < 2; i++) begin
            r6 = ready;
            d6 = done;
            if (d6 && nres < 2) begin
                res6[nres] = int'(sinx);
                nres++;
            end
            @(posedge clk);
            e++;
            if (r6 && start && na < 2) begin
                acc_e[na] = e;
                na++;
            end
            @(negedge clk);
            if (na == 2) start = 1'b0;
        end
        start = 1'b0;
        check("b2b_accepts", na, 2);
        check("b2b_results", nres, 2);
        if (na == 2) check("b2b_gap", acc_e[1] - acc_e[0], 7);
        if (nres == 2) begin
            check("b2b_res0", res6[0], 7855, 3);
            check("b2b_res1", res6[1], 7855, 3);
        end

        run_op(16'sd32767, 8'd8, 1'b0, res, lat);
        check("max_x_sinx", res, 14900, 8);
        check("max_x_lat", lat, 16);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
